// File: rtl/fish_vga_renderer.sv
// ============================================================================
// Module   : fish_vga_renderer
// Purpose  : VGA display back end for the fishing game core. Derives a 25 MHz
//            pixel enable from the 100 MHz clock, generates 640x480@60 timing,
//            and paints sky, water, rod line and fish from a per-frame
//            snapshot of the game state. Returns a one-Clk frame_tick.
// Ports    : Clk, Reset (async, active-high)
//            rpos, hook_y, fpos (signed), fish_y, fish_len, q_idle, q_done
//              - game state, sampled only at the frame snapshot
//            hSync, vSync (active low), bright, rgb - registered pixel outputs
//              that lag hCount/vCount by one pixel
//            hCount, vCount - raster counters
//            frame_tick - one-Clk pulse at the snapshot point
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fish_vga_renderer #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int WATER_Y = 150,   // assumed >= 40 so the rod top stays on screen
  parameter int FISH_H  = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  rpos,
  input  logic [9:0]  hook_y,
  input  logic [10:0] fpos,
  input  logic [9:0]  fish_y,
  input  logic [5:0]  fish_len,
  input  logic        q_idle,
  input  logic        q_done,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] SNAP_V   = 10'(V_VIS - 1);
  localparam logic [9:0] WATER_C  = 10'(WATER_Y);
  localparam logic [9:0] ROD_TOP  = 10'(WATER_Y - 40);
  localparam logic [10:0] FISH_H_C = 11'(FISH_H);

  // Pixel enable: one Clk in four.
  logic [1:0] div;
  logic       pix_en;
  assign pix_en = (div == 2'd3);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) div <= 2'd0;
    else       div <= div + 2'd1;
  end

  // Raster counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hCount <= 10'd0;
      vCount <= 10'd0;
    end else if (pix_en) begin
      if (hCount == H_LAST) begin
        hCount <= 10'd0;
        vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
      end else begin
        hCount <= hCount + 10'd1;
      end
    end
  end

  // Snapshot on the last pixel of the last visible line, so the whole
  // vertical blank is available to the game core before the next frame.
  logic at_snap;
  assign at_snap    = (hCount == H_LAST) && (vCount == SNAP_V);
  assign frame_tick = pix_en && at_snap;

  logic [9:0]  s_rpos;
  logic [9:0]  s_hook_y;
  logic [10:0] s_fpos;
  logic [9:0]  s_fish_y;
  logic [5:0]  s_fish_len;
  logic        s_idle;
  logic        s_done;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s_rpos     <= 10'd320;
      s_hook_y   <= WATER_C;
      s_fpos     <= -11'sd64;
      s_fish_y   <= WATER_C;
      s_fish_len <= 6'd0;
      s_idle     <= 1'b1;
      s_done     <= 1'b0;
    end else if (frame_tick) begin
      s_rpos     <= rpos;
      s_hook_y   <= hook_y;
      s_fpos     <= fpos;
      s_fish_y   <= fish_y;
      s_fish_len <= fish_len;
      s_idle     <= q_idle;
      s_done     <= q_done;
    end
  end

  // Pixel classification from the pre-increment counters.
  logic visible, hs_n, vs_n, on_rod, on_fish;
  logic [10:0]        x_ext, rpos_ext;
  logic signed [11:0] fx, fl, fr;
  logic [11:0]        rgb_next;

  assign visible  = (hCount < H_VIS_C) && (vCount < V_VIS_C);
  assign hs_n     = !((hCount >= HS_START) && (hCount <= HS_END));
  assign vs_n     = !((vCount >= VS_START) && (vCount <= VS_END));

  // 11-bit compare so rpos+1 cannot wrap back onto column 0.
  assign x_ext    = {1'b0, hCount};
  assign rpos_ext = {1'b0, s_rpos};
  assign on_rod   = (x_ext >= rpos_ext) && (x_ext <= rpos_ext + 11'd1) &&
                    (vCount >= ROD_TOP) && (vCount <= s_hook_y);

  // Signed 12-bit span so a negative fpos clips at the left edge.
  assign fx       = $signed({2'b00, hCount});
  assign fl       = $signed({s_fpos[10], s_fpos});
  assign fr       = fl + $signed({6'b000000, s_fish_len});
  assign on_fish  = (s_fish_len != 6'd0) && (fx >= fl) && (fx < fr) &&
                    (vCount >= s_fish_y) &&
                    ({1'b0, vCount} < {1'b0, s_fish_y} + FISH_H_C);

  always_comb begin
    rgb_next = 12'h000;
    if (!visible)              rgb_next = 12'h000;
    else if (s_done)           rgb_next = 12'h0F0;
    else if (on_rod)           rgb_next = 12'hFFF;
    else if (on_fish)          rgb_next = 12'hF80;
    else if (vCount >= WATER_C) rgb_next = s_idle ? 12'h03C : 12'h06F;
    else                       rgb_next = 12'h8CF;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hSync  <= 1'b1;
      vSync  <= 1'b1;
      bright <= 1'b0;
      rgb    <= 12'h000;
    end else if (pix_en) begin
      hSync  <= hs_n;
      vSync  <= vs_n;
      bright <= visible;
      rgb    <= rgb_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fish_vga_renderer.sv
// ============================================================================
// Module   : tb_fish_vga_renderer
// Purpose  : Self-checking bench for fish_vga_renderer on a reduced raster so
//            several whole frames fit in a short run. A behavioural model
//            derives every expected output from the Clk count since reset and
//            from the inputs it drives, and is compared every Clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fish_vga_renderer;

  localparam int H_VIS = 40, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 56, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int WATER_Y = 44, FISH_H = 8;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;   // 56
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;   // 63
  localparam int FRAME_PIX = H_TOT * V_TOT;
  localparam int SNAP_PIX  = (V_VIS - 1) * H_TOT + (H_TOT - 1);

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  rpos = 10'd0, hook_y = 10'd0, fish_y = 10'd0;
  logic [10:0] fpos = 11'd0;
  logic [5:0]  fish_len = 6'd0;
  logic        q_idle = 1'b1, q_done = 1'b0;
  logic        hSync, vSync, bright, frame_tick;
  logic [9:0]  hCount, vCount;
  logic [11:0] rgb;

  fish_vga_renderer #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .WATER_Y(WATER_Y), .FISH_H(FISH_H)
  ) dut (
    .Clk(Clk), .Reset(Reset), .rpos(rpos), .hook_y(hook_y), .fpos(fpos),
    .fish_y(fish_y), .fish_len(fish_len), .q_idle(q_idle), .q_done(q_done),
    .hSync(hSync), .vSync(vSync), .bright(bright), .hCount(hCount),
    .vCount(vCount), .rgb(rgb), .frame_tick(frame_tick)
  );

  always #5 Clk = ~Clk;

  int passed = 0, total = 0;
  int cyc = 0;   // free-running posedge count
  int n = 0;     // posedges since reset release

  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) n <= 0;
    else       n <= n + 1;
  end

  // Model of the frame snapshot.
  int m_rpos, m_hook, m_fpos, m_fy, m_len, m_idle, m_done;
  logic        e_h = 1'b1, e_v = 1'b1, e_b = 1'b0, e_ft;
  logic [11:0] e_rgb = 12'h000;
  logic [9:0]  e_hc, e_vc;

  function automatic logic [11:0] colour(int x, int y);
    if (!(x < H_VIS && y < V_VIS)) return 12'h000;
    if (m_done != 0) return 12'h0F0;
    if (x >= m_rpos && x <= m_rpos + 1 && y >= WATER_Y - 40 && y <= m_hook)
      return 12'hFFF;
    if (m_len != 0 && x >= m_fpos && x < m_fpos + m_len &&
        y >= m_fy && y < m_fy + FISH_H)
      return 12'hF80;
    if (y >= WATER_Y) return (m_idle != 0) ? 12'h03C : 12'h06F;
    return 12'h8CF;
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, got, exp);
  endtask

  always @(negedge Clk) begin
    int p, x, y, k;
    if (Reset) begin
      m_rpos = 320; m_hook = WATER_Y; m_fpos = -64; m_fy = WATER_Y;
      m_len = 0; m_idle = 1; m_done = 0;
      e_h = 1'b1; e_v = 1'b1; e_b = 1'b0; e_rgb = 12'h000;
    end else if (n > 0 && n % 4 == 0) begin
      // A pixel enable just processed pixel p of the frame.
      p = (n / 4 - 1) % FRAME_PIX;
      x = p % H_TOT;
      y = p / H_TOT;
      e_rgb = colour(x, y);
      e_b   = (x < H_VIS && y < V_VIS);
      e_h   = !(x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SYNC);
      e_v   = !(y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SYNC);
      if (p == SNAP_PIX) begin
        m_rpos = int'(rpos); m_hook = int'(hook_y); m_fpos = $signed(fpos);
        m_fy = int'(fish_y); m_len = int'(fish_len);
        m_idle = int'(q_idle); m_done = int'(q_done);
      end
    end
    k    = n / 4;
    e_hc = 10'(k % H_TOT);
    e_vc = 10'((k / H_TOT) % V_TOT);
    e_ft = !Reset && (n % 4 == 3) && (k % FRAME_PIX == SNAP_PIX);
    chk("hCount", {2'b00, hCount}, {2'b00, e_hc});
    chk("vCount", {2'b00, vCount}, {2'b00, e_vc});
    chk("hSync", {11'd0, hSync}, {11'd0, e_h});
    chk("vSync", {11'd0, vSync}, {11'd0, e_v});
    chk("bright", {11'd0, bright}, {11'd0, e_b});
    chk("rgb", rgb, e_rgb);
    chk("frame_tick", {11'd0, frame_tick}, {11'd0, e_ft});
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(posedge Clk);
    #2;
  endtask

  task automatic set_in(input int rp, input int hk, input int fp, input int fy,
                        input int fl, input logic id, input logic dn);
    rpos = 10'(rp); hook_y = 10'(hk); fpos = 11'(fp); fish_y = 10'(fy);
    fish_len = 6'(fl); q_idle = id; q_done = dn;
  endtask

  task automatic set_random();
    set_in($urandom_range(0, 45), $urandom_range(0, 62),
           int'($urandom_range(0, 60)) - 15, $urandom_range(30, 62),
           $urandom_range(0, 30), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
  endtask

  initial begin
    set_in(7, 50, 12, 46, 5, 1'b0, 1'b0);
    wait_until(5);
    Reset = 1'b0;                                 // first frame uses reset shadow
    wait_until(3000);
    set_in(3, 50, 10, 46, 8, 1'b0, 1'b0);         // fish + rod, latched at 1st snapshot
    wait_until(20000);
    set_in(3, 50, 20, 46, 8, 1'b0, 1'b0);         // mid-frame move: not yet visible
    wait_until(22000);
    set_in(39, 62, -5, 50, 12, 1'b0, 1'b0);       // left clip, last-column rod
    wait_until(34000);
    set_in(5, 55, -10, 44, 20, 1'b1, 1'b1);       // done: whole screen green
    wait_until(47000);
    set_in(10, 2, 30, 40, 20, 1'b1, 1'b0);        // hook above rod top, right clip
    for (int i = 0; i < 6; i++) begin
      wait_until(50000 + i * 1800);
      set_random();
    end
    wait_until(61000);                            // mid-frame reset
    Reset = 1'b1;
    wait_until(61004);
    Reset = 1'b0;
    wait_until(61500);
    set_random();
    wait_until(64000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
